// File: rtl/branch_resolve_queue.sv
// In-order branch prediction/resolution pairing queue driving the history-table update port.
// Update/mispredict registered one cycle after resolve; pred_ready drops when full (from registered count only).
module branch_resolve_queue #(
   parameter int DEPTH = 4,
   parameter int IDX_W = 5,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       arst_n,
   input  logic                       pred_valid,
   input  logic [IDX_W-1:0]           pred_idx,
   input  logic                       pred_taken,
   output logic                       pred_ready,
   input  logic                       res_valid,
   input  logic                       res_taken,
   input  logic                       flush,
   output logic                       upd_valid,
   output logic [IDX_W-1:0]           upd_idx,
   output logic                       upd_taken,
   output logic                       mispredict,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [CNT_W-1:0]           mispredict_cnt,
   output logic                       res_error
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW    = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic             taken;
   } entry_t;

   entry_t             mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   rd_ptr_nxt;
   logic [CW-1:0]      count_nxt;
   entry_t             head;
   logic               pop;
   logic               mis;
   logic               squash;
   logic               push;

   assign pred_ready = (count != FULL);
   assign head       = mem[rd_ptr];
   assign pop        = res_valid && (count != '0);
   assign mis        = pop && (head.taken != res_taken);
   // A mispredict or flush makes anything fetched this cycle wrong-path.
   assign squash     = flush || mis;
   assign push       = pred_valid && pred_ready && !squash;
   assign rd_ptr_nxt = pop ? rd_ptr + PTR_W'(1) : rd_ptr;

   always_comb begin
      count_nxt = count;
      if (squash) begin
         count_nxt = '0;
      end else begin
         case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{idx: pred_idx, taken: pred_taken};
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         upd_valid      <= 1'b0;
         upd_idx        <= '0;
         upd_taken      <= 1'b0;
         mispredict     <= 1'b0;
         mispredict_cnt <= '0;
         res_error      <= 1'b0;
      end else begin
         rd_ptr     <= rd_ptr_nxt;
         count      <= count_nxt;
         upd_valid  <= pop;
         mispredict <= mis;
         if (squash) begin
            wr_ptr <= rd_ptr_nxt;
         end else if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            upd_idx   <= head.idx;
            upd_taken <= res_taken;
         end
         if (mis && (mispredict_cnt != '1)) begin
            mispredict_cnt <= mispredict_cnt + CNT_W'(1);
         end
         if (res_valid && (count == '0)) begin
            res_error <= 1'b1;
         end
      end
   end

endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

In-order tracker that pairs each branch prediction issued at fetch with its resolved outcome from execute. It sits between the fetch-side prediction path and the branch history table write port. For every resolved branch it drives the table update (index, actual direction), and it raises a mispredict pulse that squashes younger in-flight predictions. It also keeps a saturating mispredict count for performance readout.

## Interface
- `DEPTH`, 4, number of in-flight branch entries; power of two, ≥2
- `IDX_W`, 5, width of the branch history table index (PC low bits)
- `CNT_W`, 16, width of the mispredict counter
- `clk`  in  1  single clock; all state updates on rising edge
- `arst_n`  in  1  reset, asynchronous, active-low
- `pred_valid`  in  1  fetch issues a conditional branch this cycle
- `pred_idx`  in  IDX_W  table index used for that prediction
- `pred_taken`  in  1  predicted direction (1 = taken)
- `pred_ready`  out  1  queue can accept a push; equals `count != DEPTH`
- `res_valid`  in  1  execute resolves the oldest outstanding branch
- `res_taken`  in  1  actual direction of that branch
- `flush`  in  1  external pipeline flush; discards all queued entries
- `upd_valid`  out  1  one-cycle write strobe to the table update port
- `upd_idx`  out  IDX_W  index to update
- `upd_taken`  out  1  actual outcome for the update (`was_taken`)
- `mispredict`  out  1  one-cycle pulse: resolved direction differed from prediction
- `count`  out  $clog2(DEPTH+1)  current number of valid entries
- `mispredict_cnt`  out  CNT_W  saturating total of mispredicts
- `res_error`  out  1  sticky: resolution arrived while the queue was empty

## Operation
- The storage is a circular FIFO of {idx, taken}, with write pointer, read pointer and `count` registers. Pointers wrap modulo DEPTH.
- Push occurs when `pred_valid && pred_ready` and no squash is active this cycle. The entry is written at the write pointer, and the write pointer increments.
- Pop occurs when `res_valid && count != 0`. The entry at the read pointer is compared with `res_taken`.
  - Next cycle: `upd_valid=1`, `upd_idx=entry.idx`, `upd_taken=res_taken`, `mispredict=(entry.taken != res_taken)`.
- A mispredict on pop squashes the queue.
  - After the pop, all remaining (younger) entries are discarded: `count` becomes 0 and the write pointer is set to the read pointer.
  - A push in the same cycle is dropped, because it is wrong-path.
- `flush` squashes the queue in the same way. A pop in the same cycle is still processed and its update is still emitted; the queue ends empty.
- Push and pop in the same cycle with no squash: both occur, and `count` is unchanged.
- Full queue: `pred_ready=0`. A push is not accepted even if a pop occurs the same cycle.
- `res_valid` with `count==0`: ignored, no update is emitted, and `res_error` is set to 1 until reset.
- `mispredict_cnt` increments on each mispredict and holds at all-ones.
- Outputs `upd_*` and `mispredict` are registered. When there is no pop, `upd_valid=0` and `mispredict=0`, and `upd_idx`/`upd_taken` hold their last value.

## Timing
- Reset (asynchronous assert, synchronous release on `clk`) sets:
  - pointers, `count`, `upd_valid`, `upd_idx`, `upd_taken`, `mispredict`, `mispredict_cnt` and `res_error` to 0
  - `pred_ready` to 1
- Reset mid-operation discards all entries immediately, and no update is emitted for them.
- Push latency: an entry pushed in cycle N is poppable in cycle N+1.
- Resolve latency: `res_valid` in cycle N gives `upd_*` and `mispredict` valid in cycle N+1, for exactly one cycle.
  - Back-to-back resolutions give back-to-back update strobes.
- `mispredict_cnt` and `count` reflect cycle-N events in cycle N+1.
- `pred_ready` is a combinational function of registered `count` only. There is no combinational path from `res_valid` or `flush`.

## Test plan
- Reset, then push idx 3 (T), 7 (NT), 12 (T), then resolve T, NT, T in three consecutive cycles.
  - Expect three `upd_valid` pulses with idx 3/7/12 and taken 1/0/1, `mispredict` never set, and `count` ending at 0.
- With DEPTH=4, push 5 back-to-back.
  - `pred_ready` goes low after 4 pushes, the 5th is not accepted, and `count=4`.
  - One pop makes `pred_ready=1` the following cycle.
- Queue holds idx 1 (T), 2 (T), 4 (NT); resolve NT while pushing idx 9 in the same cycle.
  - Next cycle: `upd_idx=1`, `upd_taken=0`, `mispredict=1`, `count=0`, idx 9 dropped, `mispredict_cnt=1`.
- Queue holds 2 entries; assert `flush` together with `res_valid`.
  - The update for the oldest entry is emitted, the queue is empty afterwards, and no mispredict is raised if the directions matched.
- Resolve on an empty queue: no `upd_valid`, `res_error=1` and held. Then push and resolve normally: the update is correct and `res_error` stays 1 until `arst_n` pulses.
- Force 2^CNT_W + 3 mispredicts (e.g. CNT_W=4 override): `mispredict_cnt` saturates at all-ones.
  - Also assert `arst_n` low mid-burst: all outputs return to reset values asynchronously.
